usb_rx_bit_decoder: RTL

Receive-side line decoder for the full-speed USB path of the miner's host interface. Samples synchronized D+/D− once per bit period and performs NRZI decoding, SYNC detection, bit-unstuffing and EOP detection. Emits one decoded data bit per valid strobe to the CRC-16/CRC-5 checkers and the byte assembler directly downstream, and drives their clear at packet start.

---
 rtl/usb_rx_pkg.sv | 29 ++
 rtl/usb_nrzi_decode.sv | 31 +++
 rtl/usb_rx_bit_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive path
// (bit decoder, byte assembler, PID checker).
package usb_rx_pkg;

  localparam int EOP_SE0_BITS = 2;
  localparam int STUFF_LIMIT  = 6;
  localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

  // Encoding is {D+, D-} so a raw line sample casts straight to this type
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECV,
    ST_EOP,
    ST_ERR
  } rx_state_t;

  function automatic logic is_data_state(input line_state_t ls);
    return (ls == LINE_J) || (ls == LINE_K);
  endfunction

endpackage

// File: rtl/usb_nrzi_decode.sv
// NRZI decoder: classifies the sampled line state and compares it with the
// previous J/K symbol to recover the data bit.
module usb_nrzi_decode
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_d_plus,
  input  logic        i_d_minus,
  input  logic        i_strobe,
  output line_state_t o_line_state,
  output logic        o_decoded
);

  line_state_t w_line;
  line_state_t r_prev_line;

  assign w_line       = line_state_t'({i_d_plus, i_d_minus});
  assign o_line_state = w_line;
  assign o_decoded    = (w_line == r_prev_line);

  // SE0/SE1 carry no NRZI information, so only J/K samples move the reference
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_line <= LINE_J;
    end else if (i_strobe && is_data_state(w_line)) begin
      r_prev_line <= w_line;
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// Full-speed USB receive bit decoder: SYNC detection, bit unstuffing and EOP
// detection on top of the NRZI decoder; all outputs are registered.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_d_plus,
  input  logic i_d_minus,
  input  logic i_bit_strobe,
  output logic o_d_orig,
  output logic o_bit_valid,
  output logic o_crc_clear,
  output logic o_receiving,
  output logic o_eop,
  output logic o_rx_error
);

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LIMIT);
  localparam logic [2:0] EOP_CNT   = 3'(EOP_SE0_BITS);
  localparam logic [2:0] IDLE_CNT  = 3'(EOP_SE0_BITS + 1);

  line_state_t w_line;
  logic        w_decoded;
  logic        w_data;

  rx_state_t   r_state, w_state_next;
  logic [2:0]  r_sync_cnt, w_sync_cnt_next;
  logic [7:0]  r_sync_sr, w_sync_sr_next;
  logic [2:0]  r_one_cnt, w_one_cnt_next;
  logic [2:0]  r_se0_cnt, w_se0_cnt_next;
  logic [2:0]  r_idle_cnt, w_idle_cnt_next;

  logic [7:0]  w_sync_shift;
  logic        w_sync_last;
  logic        w_sync_match;

  logic        w_bit_valid, w_crc_clear, w_eop, w_rx_error;

  usb_nrzi_decode u_nrzi (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_d_plus     (i_d_plus),
    .i_d_minus    (i_d_minus),
    .i_strobe     (i_bit_strobe),
    .o_line_state (w_line),
    .o_decoded    (w_decoded)
  );

  assign w_data       = is_data_state(w_line);
  assign w_sync_shift = {r_sync_sr[6:0], w_decoded};
  assign w_sync_last  = (r_sync_cnt == 3'd7);
  assign w_sync_match = (w_sync_shift == SYNC_PATTERN);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= '0;
      r_sync_sr  <= '0;
      r_one_cnt  <= '0;
      r_se0_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sync_cnt <= w_sync_cnt_next;
      r_sync_sr  <= w_sync_sr_next;
      r_one_cnt  <= w_one_cnt_next;
      r_se0_cnt  <= w_se0_cnt_next;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sync_cnt_next = r_sync_cnt;
    w_sync_sr_next  = r_sync_sr;
    w_one_cnt_next  = r_one_cnt;
    w_se0_cnt_next  = r_se0_cnt;
    w_idle_cnt_next = r_idle_cnt;
    if (i_bit_strobe) begin
      case (r_state)
        ST_IDLE: begin
          // First K after idle J is always a decoded 0 and opens SYNC
          if (w_line == LINE_K) begin
            w_state_next    = ST_SYNC;
            w_sync_cnt_next = 3'd1;
            w_sync_sr_next  = 8'h00;
          end
        end
        ST_SYNC: begin
          if (!w_data) begin
            w_state_next = ST_ERR;
          end else begin
            w_sync_sr_next  = w_sync_shift;
            w_sync_cnt_next = r_sync_cnt + 3'd1;
            if (w_sync_last) begin
              w_state_next   = w_sync_match ? ST_RECV : ST_ERR;
              w_one_cnt_next = '0;
            end
          end
        end
        ST_RECV: begin
          case (w_line)
            LINE_SE0: begin
              w_state_next   = ST_EOP;
              w_se0_cnt_next = 3'd1;
            end
            LINE_SE1: w_state_next = ST_ERR;
            default: begin
              if (r_one_cnt >= STUFF_CNT) begin
                if (w_decoded) begin
                  w_state_next = ST_ERR;
                end else begin
                  w_one_cnt_next = '0;
                end
              end else begin
                w_one_cnt_next = w_decoded ? r_one_cnt + 3'd1 : 3'd0;
              end
            end
          endcase
        end
        ST_EOP: begin
          if (w_line == LINE_SE0) begin
            if (r_se0_cnt != 3'b111) begin
              w_se0_cnt_next = r_se0_cnt + 3'd1;
            end
          end else if (w_line == LINE_J && r_se0_cnt >= EOP_CNT) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_ERR;
          end
        end
        ST_ERR: begin
          // Only an unbroken run of idle J samples lets the receiver re-arm
          if (w_line == LINE_J) begin
            if (r_idle_cnt + 3'd1 >= IDLE_CNT) begin
              w_state_next    = ST_IDLE;
              w_idle_cnt_next = '0;
            end else begin
              w_idle_cnt_next = r_idle_cnt + 3'd1;
            end
          end else begin
            w_idle_cnt_next = '0;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_bit_valid = 1'b0;
    w_crc_clear = 1'b0;
    w_eop       = 1'b0;
    w_rx_error  = 1'b0;
    if (i_bit_strobe) begin
      case (r_state)
        ST_SYNC: begin
          if (!w_data) begin
            w_rx_error = 1'b1;
          end else if (w_sync_last) begin
            w_crc_clear = w_sync_match;
            w_rx_error  = !w_sync_match;
          end
        end
        ST_RECV: begin
          if (w_line == LINE_SE1) begin
            w_rx_error = 1'b1;
          end else if (w_data) begin
            if (r_one_cnt < STUFF_CNT) begin
              w_bit_valid = 1'b1;
            end else begin
              w_rx_error = w_decoded;
            end
          end
        end
        ST_EOP: begin
          if (w_line == LINE_J && r_se0_cnt >= EOP_CNT) begin
            w_eop = 1'b1;
          end else if (w_line != LINE_SE0) begin
            w_rx_error = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_d_orig    <= 1'b0;
      o_bit_valid <= 1'b0;
      o_crc_clear <= 1'b0;
      o_receiving <= 1'b0;
      o_eop       <= 1'b0;
      o_rx_error  <= 1'b0;
    end else begin
      o_bit_valid <= w_bit_valid;
      o_crc_clear <= w_crc_clear;
      o_eop       <= w_eop;
      o_rx_error  <= w_rx_error;
      o_receiving <= (w_state_next == ST_RECV) || (w_state_next == ST_EOP);
      if (w_bit_valid) begin
        o_d_orig <= w_decoded;
      end
    end
  end

endmodule
